sfr_bus_master: RTL and testbench

- Initiator side of the SFR map interface. Accepts single load/store requests from the CPU data path and drives the SFR map's read/write strobes.
- Performs read-modify-write for byte-enabled (partial) stores.
- Returns one response per request.
- Sits between the core LSU and the SFR map, in the sys_clk domain.

---
 rtl/sfr_pkg.sv | 19 +
 rtl/sfr_byte_merge.sv | 22 ++
 rtl/sfr_bus_master.sv | 138 +++++++++++++
 tb/tb_sfr_bus_master.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sfr_pkg.sv
// rtl/sfr_pkg.sv - shared types and constants for the SFR bus master and map
package sfr_pkg;

    localparam int SFR_COUNT      = 48;
    localparam int SFR_ADDR_WIDTH = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_WAIT,
        ST_WR,
        ST_RESP
    } sfr_bus_state_t;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

endpackage

// File: rtl/sfr_byte_merge.sv
// rtl/sfr_byte_merge.sv - combinational byte-enable merge of a new word into an old word
module sfr_byte_merge
    import sfr_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]           old_word,
    input  logic [WIDTH-1:0]           new_word,
    input  logic [be_width(WIDTH)-1:0] be,
    output logic [WIDTH-1:0]           merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < be_width(WIDTH); i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/sfr_bus_master.sv
// rtl/sfr_bus_master.sv - SFR map initiator with read-modify-write; SFR_BUS_ACCESS_ERR_EN enables cpu_rsp_err
module sfr_bus_master
    import sfr_pkg::*;
#(
    parameter int SFR_WIDTH      = 32,
    parameter int SFR_ADDR_WIDTH = sfr_pkg::SFR_ADDR_WIDTH,
    parameter int SFR_COUNT      = sfr_pkg::SFR_COUNT
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    input  logic                              sys_clk_en,
    input  logic                              cpu_req_valid,
    output logic                              cpu_req_ready,
    input  logic                              cpu_req_we,
    input  logic [SFR_ADDR_WIDTH-1:0]         cpu_req_addr,
    input  logic [SFR_WIDTH-1:0]              cpu_req_wdata,
    input  logic [be_width(SFR_WIDTH)-1:0]    cpu_req_be,
    output logic                              cpu_rsp_valid,
    output logic [SFR_WIDTH-1:0]              cpu_rsp_rdata,
    output logic                              cpu_rsp_err,
    output logic [SFR_ADDR_WIDTH-1:0]         sfr_addr,
    output logic                              sfr_ren,
    output logic                              sfr_wen,
    output logic [SFR_WIDTH-1:0]              sfr_din,
    input  logic [SFR_WIDTH-1:0]              sfr_dout
);

    localparam int BE_W = be_width(SFR_WIDTH);
    // One extra bit so a count equal to 2**SFR_ADDR_WIDTH still compares correctly
    localparam logic [SFR_ADDR_WIDTH:0] ADDR_LIMIT = (SFR_ADDR_WIDTH + 1)'(SFR_COUNT);

    sfr_bus_state_t state, state_n;

    logic [SFR_ADDR_WIDTH-1:0] addr_q;
    logic                      we_q;
    logic [BE_W-1:0]           be_q;
    logic [SFR_WIDTH-1:0]      din_q;
    logic [SFR_WIDTH-1:0]      rdata_q;
    logic [SFR_WIDTH-1:0]      merged_word;

    logic accept;
    logic in_range;
    logic be_zero;
    logic be_full;

    assign cpu_req_ready = (state == ST_IDLE) && !sys_rst;
    assign accept        = cpu_req_valid && cpu_req_ready;
    assign in_range      = {1'b0, cpu_req_addr} < ADDR_LIMIT;
    assign be_zero       = (cpu_req_be == '0);
    assign be_full       = &cpu_req_be;

    assign sfr_ren       = (state == ST_RD);
    assign sfr_wen       = (state == ST_WR);
    assign cpu_rsp_valid = (state == ST_RESP);
    assign sfr_addr      = addr_q;
    assign sfr_din       = din_q;
    assign cpu_rsp_rdata = rdata_q;

    // din_q holds the store data and is overwritten in place by the merge result
    sfr_byte_merge #(
        .WIDTH (SFR_WIDTH)
    ) u_merge (
        .old_word (sfr_dout),
        .new_word (din_q),
        .be       (be_q),
        .merged   (merged_word)
    );

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (!in_range || (cpu_req_we && be_zero)) begin
                        state_n = ST_RESP;
                    end else if (cpu_req_we && be_full) begin
                        state_n = ST_WR;
                    end else begin
                        state_n = ST_RD;
                    end
                end
            end
            ST_RD:      state_n = ST_RD_WAIT;
            ST_RD_WAIT: state_n = we_q ? ST_WR : ST_RESP;
            ST_WR:      state_n = ST_RESP;
            ST_RESP:    state_n = ST_IDLE;
            default:    state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_clk_en) begin
            if (sys_rst) begin
                state   <= ST_IDLE;
                addr_q  <= '0;
                we_q    <= 1'b0;
                be_q    <= '0;
                din_q   <= '0;
                rdata_q <= '0;
            end else begin
                state <= state_n;
                if (accept) begin
                    addr_q  <= cpu_req_addr;
                    we_q    <= cpu_req_we;
                    be_q    <= cpu_req_be;
                    din_q   <= cpu_req_we ? cpu_req_wdata : '0;
                    rdata_q <= '0;
                end
                if (state == ST_RD_WAIT) begin
                    if (we_q) begin
                        din_q <= merged_word;
                    end else begin
                        rdata_q <= sfr_dout;
                    end
                end
            end
        end
    end

`ifdef SFR_BUS_ACCESS_ERR_EN
    logic err_q;

    always_ff @(posedge sys_clk) begin
        if (sys_clk_en) begin
            if (sys_rst) begin
                err_q <= 1'b0;
            end else if (accept) begin
                err_q <= !in_range || (cpu_req_we && be_zero);
            end
        end
    end

    assign cpu_rsp_err = cpu_rsp_valid && err_q;
`else
    assign cpu_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_sfr_bus_master.sv
// tb/tb_sfr_bus_master.sv - directed self-checking bench for sfr_bus_master
module tb_sfr_bus_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [5:0]  req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  sfr_addr;
    logic        sfr_ren;
    logic        sfr_wen;
    logic [31:0] sfr_din;
    logic [31:0] sfr_dout;

    logic [31:0] mem [0:63];

    int checks   = 0;
    int failures = 0;

`ifdef SFR_BUS_ACCESS_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    always #5 clk = ~clk;

    sfr_bus_master dut (
        .sys_clk       (clk),
        .sys_rst       (rst),
        .sys_clk_en    (en),
        .cpu_req_valid (req_valid),
        .cpu_req_ready (req_ready),
        .cpu_req_we    (req_we),
        .cpu_req_addr  (req_addr),
        .cpu_req_wdata (req_wdata),
        .cpu_req_be    (req_be),
        .cpu_rsp_valid (rsp_valid),
        .cpu_rsp_rdata (rsp_rdata),
        .cpu_rsp_err   (rsp_err),
        .sfr_addr      (sfr_addr),
        .sfr_ren       (sfr_ren),
        .sfr_wen       (sfr_wen),
        .sfr_din       (sfr_din),
        .sfr_dout      (sfr_dout)
    );

    // SFR map model, gated by the same clock enable
    always @(posedge clk) begin
        if (en) begin
            if (rst) begin
                for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
                mem[5]   <= 32'h12345678;
                mem[7]   <= 32'h11223344;
                sfr_dout <= 32'h0;
            end else begin
                if (sfr_wen) mem[sfr_addr] <= sfr_din;
                if (sfr_ren) sfr_dout <= mem[sfr_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic we, input logic [5:0] addr, input logic [31:0] wdata, input logic [3:0] be);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
    endtask

    initial begin
        rst = 1'b1; en = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        tick(); tick(); tick();
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_ren", sfr_ren, 0);
        chk("rst_wen", sfr_wen, 0);
        chk("rst_addr", sfr_addr, 0);
        chk("rst_din", sfr_din, 0);
        rst = 1'b0;
        tick();
        chk("idle_ready", req_ready, 1);

        // full store
        drive(1'b1, 6'd3, 32'hDEADBEEF, 4'hF);
        tick(); req_valid = 1'b0;
        chk("fs_t1_wen", sfr_wen, 1);
        chk("fs_t1_ren", sfr_ren, 0);
        chk("fs_t1_din", sfr_din, 32'hDEADBEEF);
        chk("fs_t1_addr", sfr_addr, 3);
        chk("fs_t1_rsp", rsp_valid, 0);
        chk("fs_t1_ready", req_ready, 0);
        tick();
        chk("fs_t2_rsp", rsp_valid, 1);
        chk("fs_t2_wen", sfr_wen, 0);
        chk("fs_t2_err", rsp_err, 0);
        chk("fs_t2_rdata", rsp_rdata, 0);
        tick();
        chk("fs_t3_ready", req_ready, 1);
        chk("fs_t3_rsp", rsp_valid, 0);
        chk("fs_mem3", mem[3], 32'hDEADBEEF);

        // load
        drive(1'b0, 6'd5, 32'h0, 4'h0);
        tick(); req_valid = 1'b0;
        chk("ld_t1_ren", sfr_ren, 1);
        chk("ld_t1_addr", sfr_addr, 5);
        tick();
        chk("ld_t2_ren", sfr_ren, 0);
        chk("ld_t2_rsp", rsp_valid, 0);
        tick();
        chk("ld_t3_rsp", rsp_valid, 1);
        chk("ld_t3_rdata", rsp_rdata, 32'h12345678);
        chk("ld_t3_err", rsp_err, 0);
        tick();

        // partial store
        drive(1'b1, 6'd7, 32'hAABBCCDD, 4'h5);
        tick(); req_valid = 1'b0;
        chk("ps_t1_ren", sfr_ren, 1);
        chk("ps_t1_wen", sfr_wen, 0);
        tick();
        chk("ps_t2_wen", sfr_wen, 0);
        tick();
        chk("ps_t3_wen", sfr_wen, 1);
        chk("ps_t3_din", sfr_din, 32'h11BB33DD);
        chk("ps_t3_rsp", rsp_valid, 0);
        tick();
        chk("ps_t4_rsp", rsp_valid, 1);
        chk("ps_t4_rdata", rsp_rdata, 0);
        chk("ps_mem7", mem[7], 32'h11BB33DD);
        tick();

        // out-of-range load
        drive(1'b0, 6'd50, 32'h0, 4'h0);
        tick(); req_valid = 1'b0;
        chk("oor_t1_rsp", rsp_valid, 1);
        chk("oor_t1_ren", sfr_ren, 0);
        chk("oor_t1_wen", sfr_wen, 0);
        chk("oor_t1_rdata", rsp_rdata, 0);
        chk("oor_t1_err", rsp_err, ERR_EXP);
        tick();
        chk("oor_t2_ready", req_ready, 1);

        // store with no byte enables
        drive(1'b1, 6'd4, 32'hCAFEF00D, 4'h0);
        tick(); req_valid = 1'b0;
        chk("be0_t1_rsp", rsp_valid, 1);
        chk("be0_t1_wen", sfr_wen, 0);
        chk("be0_t1_ren", sfr_ren, 0);
        chk("be0_t1_err", rsp_err, ERR_EXP);
        tick();
        chk("be0_mem4", mem[4], 0);

        // clock-enable freeze during RD_WAIT
        drive(1'b0, 6'd5, 32'h0, 4'h0);
        tick(); req_valid = 1'b0;
        chk("frz_t1_ren", sfr_ren, 1);
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_hold_rsp", rsp_valid, 0);
            chk("frz_hold_ready", req_ready, 0);
        end
        en = 1'b1;
        tick();
        chk("frz_rsp", rsp_valid, 1);
        chk("frz_rdata", rsp_rdata, 32'h12345678);
        tick();
        chk("frz_after_rsp", rsp_valid, 0);

        // reset during WR
        drive(1'b1, 6'd9, 32'h0BADF00D, 4'hF);
        tick(); req_valid = 1'b0;
        chk("rw_t1_wen", sfr_wen, 1);
        rst = 1'b1;
        tick();
        chk("rw_wen", sfr_wen, 0);
        chk("rw_rsp", rsp_valid, 0);
        chk("rw_ready_in_rst", req_ready, 0);
        rst = 1'b0;
        tick();
        chk("rw_rsp_after", rsp_valid, 0);
        chk("rw_ready_after", req_ready, 1);

        // back-to-back loads with valid held
        drive(1'b0, 6'd5, 32'h0, 4'h0);
        tick();
        req_addr = 6'd7;
        chk("bb_t1_ready", req_ready, 0);
        chk("bb_t1_ren", sfr_ren, 1);
        tick();
        chk("bb_t2_ready", req_ready, 0);
        tick();
        chk("bb_t3_ready", req_ready, 0);
        chk("bb_t3_rsp", rsp_valid, 1);
        chk("bb_t3_rdata", rsp_rdata, 32'h12345678);
        tick();
        chk("bb_t4_ready", req_ready, 1);
        chk("bb_t4_rsp", rsp_valid, 0);
        tick(); req_valid = 1'b0;
        chk("bb_t5_ready", req_ready, 0);
        chk("bb_t5_ren", sfr_ren, 1);
        chk("bb_t5_addr", sfr_addr, 7);
        tick();
        tick();
        chk("bb_t7_rsp", rsp_valid, 1);
        chk("bb_t7_rdata", rsp_rdata, 32'h11223344);
        tick();
        chk("bb_t8_rsp", rsp_valid, 0);
        chk("bb_t8_ready", req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
